// File: rtl/aes_word_loader.sv
`default_nettype none
// ============================================================================
// Module  : aes_word_loader
// Brief   : Assembles key, sbox seed and plaintext from a 32-bit word stream,
//           holds them on the encryption core and returns its result.
// Revision: 1.0
// ============================================================================
module aes_word_loader #(
    parameter int N        = 256,
    parameter int CORE_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [1:0]    s_sel,
    input  logic [31:0]   s_data,
    output logic [127:0]  core_in,
    output logic [N-1:0]  core_key,
    output logic [N-1:0]  core_seed,
    input  logic [127:0]  core_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [127:0]  m_data,
    output logic          err
);

    localparam int c_KEY_WORDS = N / 32;
    localparam int c_MAX_GROUP = (c_KEY_WORDS > 4) ? c_KEY_WORDS : 4;
    localparam int c_CNT_W     = $clog2(c_MAX_GROUP + 1);
    localparam int c_LAT_W     = $clog2(CORE_LAT + 1);

    localparam logic [1:0] c_SEL_DATA = 2'd0;
    localparam logic [1:0] c_SEL_KEY  = 2'd1;
    localparam logic [1:0] c_SEL_SEED = 2'd2;
    localparam logic [1:0] c_SEL_RSV  = 2'd3;

    localparam logic [c_CNT_W-1:0] c_FIRST     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(4);
    localparam logic [c_CNT_W-1:0] c_KEY_LAST  = c_CNT_W'(c_KEY_WORDS);
    localparam logic [c_LAT_W-1:0] c_LAT_INIT  = c_LAT_W'(CORE_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [127:0]         data_q, data_d;
    logic [N-1:0]         key_q, key_d;
    logic [N-1:0]         seed_q, seed_d;
    logic                 key_ok_q, key_ok_d;
    logic                 seed_ok_q, seed_ok_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           cur_sel_q, cur_sel_d;
    logic [c_LAT_W-1:0]   lat_q, lat_d;
    logic                 m_valid_q, m_valid_d;
    logic [127:0]         m_data_q, m_data_d;
    logic                 err_q, err_d;

    logic                 w_accept;
    logic [c_CNT_W-1:0]   w_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            key_q     <= '0;
            seed_q    <= '0;
            key_ok_q  <= 1'b0;
            seed_ok_q <= 1'b0;
            cnt_q     <= '0;
            cur_sel_q <= 2'd0;
            lat_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            key_q     <= key_d;
            seed_q    <= seed_d;
            key_ok_q  <= key_ok_d;
            seed_ok_q <= seed_ok_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            lat_q     <= lat_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        key_d     = key_q;
        seed_d    = seed_q;
        key_ok_d  = key_ok_q;
        seed_ok_d = seed_ok_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        lat_d     = lat_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        err_d     = 1'b0;
        w_accept  = s_valid && s_ready;
        w_pos     = cnt_q + c_FIRST;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (s_sel == c_SEL_RSV) begin
                        err_d = 1'b1;
                    end else begin
                        // A word for a different target abandons the partial group
                        if ((cnt_q != '0) && (s_sel != cur_sel_q)) begin
                            err_d = 1'b1;
                            w_pos = c_FIRST;
                        end
                        cur_sel_d = s_sel;
                        cnt_d     = w_pos;
                        if (s_sel == c_SEL_DATA) begin
                            data_d = {data_q[95:0], s_data};
                            if (w_pos == c_DATA_LAST) begin
                                cnt_d = '0;
                                if (key_ok_q && seed_ok_q) begin
                                    state_d = S_WAIT;
                                    lat_d   = c_LAT_INIT;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end else if (s_sel == c_SEL_KEY) begin
                            key_d = N'({key_q, s_data});
                            if (w_pos == c_FIRST) key_ok_d = 1'b0;
                            if (w_pos == c_KEY_LAST) begin
                                cnt_d    = '0;
                                key_ok_d = 1'b1;
                            end
                        end else begin
                            seed_d = N'({seed_q, s_data});
                            if (w_pos == c_FIRST) seed_ok_d = 1'b0;
                            if (w_pos == c_KEY_LAST) begin
                                cnt_d     = '0;
                                seed_ok_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    m_data_d  = core_out;
                    m_valid_d = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign s_ready   = (state_q == S_IDLE) && !rst;
    assign core_in   = data_q;
    assign core_key  = key_q;
    assign core_seed = seed_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_word_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_word_loader
// Brief   : Self-checking bench for aes_word_loader with a registered stub core.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aes_word_loader;

    localparam int N        = 256;
    localparam int CORE_LAT = 2;
    localparam int KW       = N / 32;
    localparam int CW       = (N > 128) ? N : 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    s_sel = 2'd0;
    logic [31:0]   s_data = 32'd0;
    logic [127:0]  core_in;
    logic [N-1:0]  core_key;
    logic [N-1:0]  core_seed;
    logic [127:0]  core_out = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [127:0]  m_data;
    logic          err;

    always #5 clk = ~clk;

    always_ff @(posedge clk) core_out <= core_in ^ core_key[127:0] ^ core_seed[127:0];

    aes_word_loader #(.N(N), .CORE_LAT(CORE_LAT)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_sel(s_sel), .s_data(s_data), .core_in(core_in), .core_key(core_key),
        .core_seed(core_seed), .core_out(core_out), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .err(err)
    );

    int errors = 0;
    int checks = 0;
    bit rand_mr = 0;
    bit last_acc = 0;

    // Reference model: per-target word history, group progress and result timing
    logic [31:0]  dq[$];
    logic [31:0]  kq[$];
    logic [31:0]  sq[$];
    int           pend_n = 0;
    logic [1:0]   pend_sel = 2'd0;
    bit           key_ok = 0, seed_ok = 0, busy = 0, hold_v = 0, exp_err = 0;
    int           cyc = 0, due = 0;
    logic [127:0] res = '0, exp_m = '0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] hist_val(input int which);
        logic [N-1:0] v;
        v = '0;
        if (which == 0)      foreach (dq[i]) v = (v << 32) | N'(dq[i]);
        else if (which == 1) foreach (kq[i]) v = (v << 32) | N'(kq[i]);
        else                 foreach (sq[i]) v = (v << 32) | N'(sq[i]);
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit acc, input logic [1:0] sel,
                              input logic [31:0] w, input bit mr);
        int gs;
        logic [N-1:0] kv, sv, dv;
        cyc++;
        exp_err = 0;
        if (r) begin
            dq.delete(); kq.delete(); sq.delete();
            pend_n = 0; key_ok = 0; seed_ok = 0; busy = 0; hold_v = 0; exp_m = '0;
        end else begin
            if (hold_v && mr) begin
                hold_v = 0; busy = 0;
            end else if (busy && !hold_v && cyc == due) begin
                hold_v = 1; exp_m = res;
            end
            if (acc && sel == 2'd3) begin
                exp_err = 1;
            end else if (acc) begin
                if (sel == 2'd0) begin dq.push_back(w); if (dq.size() > 4)  void'(dq.pop_front()); end
                if (sel == 2'd1) begin kq.push_back(w); if (kq.size() > KW) void'(kq.pop_front()); end
                if (sel == 2'd2) begin sq.push_back(w); if (sq.size() > KW) void'(sq.pop_front()); end
                if (pend_n != 0 && sel != pend_sel) begin
                    exp_err = 1; pend_n = 0;
                end
                pend_sel = sel;
                pend_n++;
                gs = (sel == 2'd0) ? 4 : KW;
                if (pend_n == 1 && sel == 2'd1) key_ok = 0;
                if (pend_n == 1 && sel == 2'd2) seed_ok = 0;
                if (pend_n == gs) begin
                    pend_n = 0;
                    if (sel == 2'd1) key_ok = 1;
                    else if (sel == 2'd2) seed_ok = 1;
                    else if (key_ok && seed_ok) begin
                        kv = hist_val(1); sv = hist_val(2); dv = hist_val(0);
                        res  = dv[127:0] ^ kv[127:0] ^ sv[127:0];
                        busy = 1;
                        due  = cyc + CORE_LAT + 1;
                    end else begin
                        exp_err = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        bit acc, exp_rdy, r, mr;
        logic [1:0] sel;
        logic [31:0] w;
        logic [N-1:0] dv;
        if (rand_mr) m_ready = 1'($urandom_range(0, 1));
        #1;
        exp_rdy = !busy && !rst;
        chk("s_ready", s_ready, exp_rdy);
        acc = s_valid && exp_rdy;
        last_acc = acc;
        sel = s_sel; w = s_data; r = rst; mr = m_ready;
        @(posedge clk);
        #1;
        model_edge(r, acc, sel, w, mr);
        dv = hist_val(0);
        chk("err", err, exp_err);
        chk("m_valid", m_valid, hold_v);
        chk("m_data", m_data, exp_m);
        chk("core_in", core_in, dv[127:0]);
        chk("core_key", core_key, hist_val(1));
        chk("core_seed", core_seed, hist_val(2));
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_word(input logic [1:0] sel, input logic [31:0] w, output int n);
        s_valid = 1'b1; s_sel = sel; s_data = w; n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        chk("send_accepted", last_acc, 1'b1);
    endtask

    task automatic load_rand(input logic [1:0] sel, input int cnt, input bit gaps);
        int n;
        for (int i = 0; i < cnt; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_word(sel, $urandom, n);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid();
        int n;
        n = 0;
        while (!m_valid && n < 50) begin tick(); n++; end
        chk("m_valid_timeout", m_valid, 1'b1);
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] data;
        logic        mr;
        logic        exp_err;
        logic        exp_mv;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        int n;
        logic [127:0] held;

        // Test 1 vectors: known key, zero seed, known plaintext
        for (int k = 0; k < 8; k++) begin
            v.v = 1; v.sel = 2'd1;
            v.data = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            v.mr = 1; v.exp_err = 0; v.exp_mv = 0;
            tbl.push_back(v);
        end
        for (int k = 0; k < 8; k++) begin
            v.v = 1; v.sel = 2'd2; v.data = 32'd0; v.mr = 1; v.exp_err = 0; v.exp_mv = 0;
            tbl.push_back(v);
        end
        v.v = 1; v.sel = 2'd0; v.mr = 1; v.exp_err = 0; v.exp_mv = 0;
        v.data = 32'h00112233; tbl.push_back(v);
        v.data = 32'h44556677; tbl.push_back(v);
        v.data = 32'h8899aabb; tbl.push_back(v);
        v.data = 32'hccddeeff; tbl.push_back(v);
        v.v = 0; v.data = 32'd0;
        v.exp_mv = 0; tbl.push_back(v);
        v.exp_mv = 0; tbl.push_back(v);
        v.exp_mv = 1; tbl.push_back(v);
        v.exp_mv = 0; tbl.push_back(v);

        // Reset
        rst = 1'b1;
        idle(2);
        chk("reset_s_ready", s_ready, 1'b0);
        chk("reset_m_valid", m_valid, 1'b0);
        rst = 1'b0;

        // Test 1: table-driven
        foreach (tbl[i]) begin
            s_valid = tbl[i].v; s_sel = tbl[i].sel; s_data = tbl[i].data; m_ready = tbl[i].mr;
            tick();
            chk("t1_accept", last_acc, tbl[i].v);
            chk("t1_err", err, tbl[i].exp_err);
            chk("t1_mv", m_valid, tbl[i].exp_mv);
            if (tbl[i].exp_mv)
                chk("t1_mdata", m_data, 128'h10003020_50407060_9080b0a0_d0c0f0e0);
        end
        m_ready = 1'b1;

        // Test 2: data before any key, then load and resend
        rst = 1'b1; idle(1); rst = 1'b0;
        load_rand(2'd0, 4, 0);
        chk("t2_err", err, 1'b1);
        idle(6);
        chk("t2_no_mv", m_valid, 1'b0);
        load_rand(2'd1, KW, 1);
        load_rand(2'd2, KW, 1);
        load_rand(2'd0, 4, 1);
        wait_mvalid();
        tick();

        // Test 3: downstream back-pressure in HOLD
        m_ready = 1'b0;
        load_rand(2'd0, 4, 0);
        wait_mvalid();
        held = m_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_mv", m_valid, 1'b1);
            chk("t3_hold", m_data, held);
            chk("t3_s_ready", s_ready, 1'b0);
        end
        m_ready = 1'b1;
        tick();
        chk("t3_released", m_valid, 1'b0);
        chk("t3_ready_back", s_ready, 1'b1);

        // Test 4: partial key abandoned by a data word
        load_rand(2'd1, 3, 0);
        load_rand(2'd0, 1, 0);
        chk("t4_abandon_err", err, 1'b1);
        load_rand(2'd0, 3, 0);
        chk("t4_block_rejected", err, 1'b1);
        load_rand(2'd0, 4, 0);
        chk("t4_block2_rejected", err, 1'b1);
        idle(5);
        chk("t4_no_mv", m_valid, 1'b0);
        load_rand(2'd1, KW, 0);
        load_rand(2'd0, 4, 0);
        wait_mvalid();
        tick();

        // Test 5: reserved word, then reset during WAIT
        load_rand(2'd3, 1, 0);
        chk("t5_rsv_err", err, 1'b1);
        chk("t5_rsv_ready", s_ready, 1'b1);
        load_rand(2'd0, 4, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_mv", m_valid, 1'b0);
        chk("t5_rst_key", core_key, '0);
        chk("t5_rst_in", core_in, '0);
        chk("t5_rst_ready", s_ready, 1'b0);
        rst = 1'b0;
        idle(6);
        chk("t5_no_mv", m_valid, 1'b0);
        load_rand(2'd0, 4, 0);
        chk("t5_keyok_cleared", err, 1'b1);

        // Test 6: back-to-back blocks with s_valid held high
        load_rand(2'd1, KW, 0);
        load_rand(2'd2, KW, 0);
        for (int i = 0; i < 4; i++) send_word(2'd0, $urandom, n);
        send_word(2'd0, $urandom, n);
        chk("t6_stall_len", n, CORE_LAT + 3);
        for (int i = 0; i < 3; i++) send_word(2'd0, $urandom, n);
        s_valid = 1'b0;
        wait_mvalid();
        tick();

        // Randomized traffic against the model
        rand_mr = 1;
        for (int op = 0; op < 300; op++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: load_rand(2'd0, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4, 1);
                3:       load_rand(2'd1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, KW) : KW, 1);
                4:       load_rand(2'd2, ($urandom_range(0, 3) == 0) ? $urandom_range(1, KW) : KW, 1);
                5:       load_rand(2'd3, 1, 0);
                6:       begin
                             if ($urandom_range(0, 7) == 0) begin
                                 rst = 1'b1; idle(1); rst = 1'b0;
                             end else idle(1);
                         end
                default: idle($urandom_range(1, 5));
            endcase
        end
        rand_mr = 0;
        m_ready = 1'b1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
